// File: rtl/mux_onehot3_chk_if.sv
// mux_onehot3_chk_if
//   Bundles the data and checker signals of mux_onehot3_chk.
//   master : drives in0/in1/in2/sel/clr_err, observes out/sel_err/err_sticky/err_cnt
//   slave  : the multiplexer/checker side
//   Parameters: WIDTH (data width), CNT_WIDTH (error counter width).
interface mux_onehot3_chk_if #(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 8
);
   logic [WIDTH-1:0]     in0;
   logic [WIDTH-1:0]     in1;
   logic [WIDTH-1:0]     in2;
   logic [2:0]           sel;
   logic                 clr_err;
   logic [WIDTH-1:0]     out;
   logic                 sel_err;
   logic                 err_sticky;
   logic [CNT_WIDTH-1:0] err_cnt;

   modport master (
      output in0, in1, in2, sel, clr_err,
      input  out, sel_err, err_sticky, err_cnt
   );

   modport slave (
      input  in0, in1, in2, sel, clr_err,
      output out, sel_err, err_sticky, err_cnt
   );
endinterface

// File: rtl/mux_onehot3_chk.sv
// mux_onehot3_chk
//   Three-input one-hot multiplexer with a select-legality checker.
//   The data path is purely combinational; clk/reset_n only serve the
//   checker state (sticky error flag and saturating error-cycle counter).
// Ports:
//   clk      : checker clock, rising edge
//   reset_n  : asynchronous active-low reset of err_sticky/err_cnt
//   bus      : slave side of mux_onehot3_chk_if
//              in0/in1/in2, sel (one-hot), clr_err (sync clear)
//              out (comb), sel_err (comb), err_sticky, err_cnt (registered)
// Build option:
//   MUX1HOT3_ZERO_ON_ERR_EN : when defined, out is forced to zero whenever
//   sel is not exactly one-hot. Checker behaviour is the same in both builds.
module mux_onehot3_chk #(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   mux_onehot3_chk_if.slave      bus
);

   logic [WIDTH-1:0]     and_or;
   logic                 sel_err;
   logic                 err_sticky_d;
   logic                 err_sticky_q;
   logic [CNT_WIDTH-1:0] err_cnt_d;
   logic [CNT_WIDTH-1:0] err_cnt_q;

   always_comb begin
      and_or = ({WIDTH{bus.sel[0]}} & bus.in0)
             | ({WIDTH{bus.sel[1]}} & bus.in1)
             | ({WIDTH{bus.sel[2]}} & bus.in2);
   end

   always_comb begin
      unique case (bus.sel)
         3'b001, 3'b010, 3'b100: sel_err = 1'b0;
         default:                sel_err = 1'b1;
      endcase
   end

`ifdef MUX1HOT3_ZERO_ON_ERR_EN
   assign bus.out = sel_err ? '0 : and_or;
`else
   assign bus.out = and_or;
`endif

   assign bus.sel_err = sel_err;

   // Clear takes priority over a simultaneous error; the counter stops at
   // all-ones instead of wrapping.
   always_comb begin
      err_sticky_d = err_sticky_q;
      err_cnt_d    = err_cnt_q;
      if (bus.clr_err) begin
         err_sticky_d = 1'b0;
         err_cnt_d    = '0;
      end else if (sel_err) begin
         err_sticky_d = 1'b1;
         if (!(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_sticky_q <= 1'b0;
         err_cnt_q    <= '0;
      end else begin
         err_sticky_q <= err_sticky_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign bus.err_sticky = err_sticky_q;
   assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_mux_onehot3_chk.sv
module tb_mux_onehot3_chk;

   logic clk;
   logic reset_n;
   int   tests;
   int   fails;

   // dut_a: 8-bit counter; dut_b: 2-bit counter for saturation checks
   mux_onehot3_chk_if #(.WIDTH(3), .CNT_WIDTH(8)) if_a ();
   mux_onehot3_chk_if #(.WIDTH(3), .CNT_WIDTH(2)) if_b ();

   mux_onehot3_chk #(.WIDTH(3), .CNT_WIDTH(8)) dut_a (
      .clk(clk), .reset_n(reset_n), .bus(if_a.slave));
   mux_onehot3_chk #(.WIDTH(3), .CNT_WIDTH(2)) dut_b (
      .clk(clk), .reset_n(reset_n), .bus(if_b.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] sel;
      logic [2:0] in0;
      logic [2:0] in1;
      logic [2:0] in2;
      logic [2:0] exp_out;   // AND-OR result
      logic       exp_err;
   } vec_t;

   vec_t vecs [16];

   function automatic vec_t mk(logic [2:0] s, logic [2:0] a, logic [2:0] b,
                               logic [2:0] c, logic [2:0] o, logic e);
      vec_t v;
      v.sel = s; v.in0 = a; v.in1 = b; v.in2 = c; v.exp_out = o; v.exp_err = e;
      return v;
   endfunction

   function automatic logic [2:0] exp_mux(logic [2:0] and_or_val, logic err);
`ifdef MUX1HOT3_ZERO_ON_ERR_EN
      return err ? 3'b000 : and_or_val;
`else
      return and_or_val;
`endif
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_in(logic [2:0] a, logic [2:0] b, logic [2:0] c);
      if_a.in0 = a; if_a.in1 = b; if_a.in2 = c;
      if_b.in0 = a; if_b.in1 = b; if_b.in2 = c;
   endtask

   task automatic set_ctl(logic [2:0] s, logic clr);
      if_a.sel = s; if_a.clr_err = clr;
      if_b.sel = s; if_b.clr_err = clr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(string name, logic sticky, logic [7:0] cnt_a,
                              logic [1:0] cnt_b);
      check({name, "_sticky_a"}, 32'(if_a.err_sticky), 32'(sticky));
      check({name, "_cnt_a"},    32'(if_a.err_cnt),    32'(cnt_a));
      check({name, "_sticky_b"}, 32'(if_b.err_sticky), 32'(sticky));
      check({name, "_cnt_b"},    32'(if_b.err_cnt),    32'(cnt_b));
   endtask

   initial begin
      tests = 0;
      fails = 0;

      vecs[0]  = mk(3'b001, 3'b000, 3'b001, 3'b010, 3'b000, 1'b0);
      vecs[1]  = mk(3'b010, 3'b000, 3'b001, 3'b010, 3'b001, 1'b0);
      vecs[2]  = mk(3'b100, 3'b000, 3'b001, 3'b010, 3'b010, 1'b0);
      vecs[3]  = mk(3'b000, 3'b000, 3'b001, 3'b010, 3'b000, 1'b1);
      vecs[4]  = mk(3'b011, 3'b000, 3'b001, 3'b010, 3'b001, 1'b1);
      vecs[5]  = mk(3'b101, 3'b000, 3'b001, 3'b010, 3'b010, 1'b1);
      vecs[6]  = mk(3'b110, 3'b000, 3'b001, 3'b010, 3'b011, 1'b1);
      vecs[7]  = mk(3'b111, 3'b000, 3'b001, 3'b010, 3'b011, 1'b1);
      vecs[8]  = mk(3'b001, 3'b101, 3'b011, 3'b110, 3'b101, 1'b0);
      vecs[9]  = mk(3'b010, 3'b101, 3'b011, 3'b110, 3'b011, 1'b0);
      vecs[10] = mk(3'b100, 3'b101, 3'b011, 3'b110, 3'b110, 1'b0);
      vecs[11] = mk(3'b000, 3'b101, 3'b011, 3'b110, 3'b000, 1'b1);
      vecs[12] = mk(3'b011, 3'b101, 3'b011, 3'b110, 3'b111, 1'b1);
      vecs[13] = mk(3'b101, 3'b101, 3'b011, 3'b110, 3'b111, 1'b1);
      vecs[14] = mk(3'b110, 3'b101, 3'b011, 3'b110, 3'b111, 1'b1);
      vecs[15] = mk(3'b111, 3'b101, 3'b011, 3'b110, 3'b111, 1'b1);

      // Reset state: cleared asynchronously before any clock edge
      reset_n = 1'b0;
      set_in(3'b000, 3'b001, 3'b010);
      set_ctl(3'b001, 1'b0);
      #2;
      check_state("reset", 1'b0, 8'd0, 2'd0);
      tick();
      tick();
      #2 reset_n = 1'b1;

      // Combinational table, clr_err held so the checker stays cleared
      set_ctl(3'b001, 1'b1);
      for (int i = 0; i < 16; i++) begin
         set_in(vecs[i].in0, vecs[i].in1, vecs[i].in2);
         set_ctl(vecs[i].sel, 1'b1);
         #1;
         check($sformatf("tbl%0d_out", i), 32'(if_a.out),
               32'(exp_mux(vecs[i].exp_out, vecs[i].exp_err)));
         check($sformatf("tbl%0d_err", i), 32'(if_a.sel_err), 32'(vecs[i].exp_err));
      end
      tick();
      set_ctl(3'b001, 1'b0);
      set_in(3'b000, 3'b001, 3'b010);
      tick();
      check_state("after_tbl", 1'b0, 8'd0, 2'd0);

      // Legal one-hot walk: no error accumulation
      for (int i = 0; i < 3; i++) begin
         logic [2:0] s;
         s = 3'b001 << i;
         set_ctl(s, 1'b0);
         #1;
         check($sformatf("walk%0d_out", i), 32'(if_a.out), 32'(i));
         check($sformatf("walk%0d_err", i), 32'(if_a.sel_err), 32'd0);
         tick();
      end
      check_state("walk", 1'b0, 8'd0, 2'd0);

      // sel=111 for one edge
      set_ctl(3'b111, 1'b0);
      #1;
      check("s111_out", 32'(if_a.out), 32'(exp_mux(3'b011, 1'b1)));
      check("s111_err", 32'(if_a.sel_err), 32'd1);
      tick();
      check_state("s111", 1'b1, 8'd1, 2'd1);

      // sel=000 for three edges
      set_ctl(3'b000, 1'b0);
      #1;
      check("s000_out", 32'(if_a.out), 32'd0);
      check("s000_err", 32'(if_a.sel_err), 32'd1);
      tick(); tick(); tick();
      check_state("s000", 1'b1, 8'd4, 2'd3);

      // Glitch between edges must not reach the registers
      set_ctl(3'b001, 1'b0);
      tick();
      #2 set_ctl(3'b111, 1'b0);
      #1 check("glitch_err", 32'(if_a.sel_err), 32'd1);
      #1 set_ctl(3'b001, 1'b0);
      tick();
      check_state("glitch", 1'b1, 8'd4, 2'd3);

      // Clear wins over a simultaneous error, then counting resumes
      set_ctl(3'b110, 1'b1);
      tick();
      check_state("clr_win", 1'b0, 8'd0, 2'd0);
      set_ctl(3'b110, 1'b0);
      tick();
      check_state("clr_resume", 1'b1, 8'd1, 2'd1);

      // Saturation of the 2-bit counter
      set_ctl(3'b110, 1'b1);
      tick();
      set_ctl(3'b110, 1'b0);
      for (int i = 1; i <= 6; i++) begin
         tick();
         check_state($sformatf("sat%0d", i), 1'b1, 8'(i), (i >= 3) ? 2'd3 : 2'(i));
      end

      // Reset asserted between edges with err_cnt=2
      set_ctl(3'b110, 1'b1);
      tick();
      set_ctl(3'b110, 1'b0);
      tick(); tick();
      check_state("pre_rst", 1'b1, 8'd2, 2'd2);
      #2 reset_n = 1'b0;
      #1 check_state("mid_rst", 1'b0, 8'd0, 2'd0);
      set_ctl(3'b010, 1'b0);
      #1;
      check("rst_out", 32'(if_a.out), 32'd1);
      check("rst_err", 32'(if_a.sel_err), 32'd0);
      set_ctl(3'b110, 1'b0);
      tick();
      check_state("rst_held", 1'b0, 8'd0, 2'd0);
      #2 reset_n = 1'b1;
      tick();
      check_state("rst_release", 1'b1, 8'd1, 2'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mux_onehot3_chk.md
Name: mux_onehot3_chk

Overview:
- Three-input, parameterised-width one-hot multiplexer with a combinational data path.
- Adds a select-legality checker: combinational error flag, registered sticky flag, saturating error-cycle counter.
- Used wherever a decoded one-hot select steers one of three equal-width buses.
- The data path has no clock dependency; clock and reset serve only the checker state.

Parameters:
- WIDTH, 8, data width of in0/in1/in2/out in bits (legal >= 1).
- CNT_WIDTH, 8, width of err_cnt in bits (legal >= 1).

Ports:
- clk  input  1  checker clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in0  input  WIDTH  data input, selected by sel[0].
- in1  input  WIDTH  data input, selected by sel[1].
- in2  input  WIDTH  data input, selected by sel[2].
- sel  input  3  one-hot select.
- clr_err  input  1  synchronous clear of err_sticky and err_cnt.
- out  output  WIDTH  multiplexed data, combinational.
- sel_err  output  1  combinational; 1 when sel is not exactly one-hot.
- err_sticky  output  1  registered; set by any clocked sel_err.
- err_cnt  output  CNT_WIDTH  registered, saturating count of clk edges sampled with sel_err=1.

Behaviour:
- Data path (zero latency, no register):
  - out = ({WIDTH{sel[0]}} & in0) | ({WIDTH{sel[1]}} & in1) | ({WIDTH{sel[2]}} & in2).
  - sel=001 -> in0; sel=010 -> in1; sel=100 -> in2.
  - sel=000 -> out all zeros.
  - Multi-hot sel -> bitwise OR of the selected inputs (default build; see Optional Feature).
- sel_err is combinational: 1 for sel in {000, 011, 101, 110, 111}, else 0.
- Reset: while reset_n=0, err_sticky=0 and err_cnt=0, asynchronously and regardless of clk. out and sel_err are unaffected by reset.
- On each rising clk edge with reset_n=1, evaluated in priority order:
  1. clr_err=1: err_sticky<=0, err_cnt<=0. Clear wins even if sel_err=1 on the same edge.
  2. Else if sel_err=1: err_sticky<=1; err_cnt<=err_cnt+1, saturating at all-ones (never wraps).
  3. Else: hold.
- Reset deassertion takes effect on the first rising edge after reset_n goes high.
- Reset asserted mid-operation clears the state immediately.
- Register-bearing inputs are sampled only at rising clk edges; sel glitches between edges affect only out and sel_err.

Optional Feature:
- Macro: MUX1HOT3_ZERO_ON_ERR_EN.
- When defined: out is forced to all zeros whenever sel_err=1 (multi-hot or zero select), giving a safe idle value.
- When undefined: AND-OR behaviour above, so multi-hot selects OR the chosen inputs.
- Checker outputs (sel_err, err_sticky, err_cnt) behave identically in both builds.

Test Plan:
- WIDTH=3, in0=000, in1=001, in2=010; sel sequence 001, 010, 100, changing on rising edges -> out=000, 001, 010 respectively, each within the same cycle; sel_err=0; err_cnt stays 0 and err_sticky=0.
- Same inputs, sel=111 held for 1 edge -> sel_err=1. Default build: out=011. With MUX1HOT3_ZERO_ON_ERR_EN: out=000. After the edge, err_sticky=1 and err_cnt=1.
- sel=000 for 3 edges -> out=000 in both builds, sel_err=1, err_cnt increments by 3.
- CNT_WIDTH=2, sel=110 held for 6 edges -> err_cnt goes 1, 2, 3, 3, 3, 3 (saturates).
- With err_cnt>0, assert clr_err together with sel_err=1 for one edge -> err_cnt=0, err_sticky=0. Next edge with sel still bad and clr_err=0 -> err_cnt=1.
- With err_cnt=2, drive reset_n low between clock edges -> err_cnt=0 and err_sticky=0 immediately; out continues to follow sel and the inputs during reset.
